// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
// One 32-bit word per line; read hits answer combinationally, misses and stores stall the CPU.
module data_cache #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [XLEN-1:0]  cpu_addr,
  input  logic [7:0]       cpu_wdata [0:3],
  input  logic             cpu_read,
  input  logic             cpu_write,
  output logic [7:0]       cpu_rdata [0:3],
  output logic             cpu_stall,
  output logic [XLEN-1:0]  mem_addr,
  output logic [7:0]       mem_wdata [0:3],
  input  logic [7:0]       mem_rdata [0:3],
  output logic             mem_read,
  output logic             mem_write,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = XLEN - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;

  // Tag and data arrays are deliberately left out of reset; valid bits gate them.
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [31:0]           cpu_wdata_w, mem_rdata_w, rdata_out;
  logic [INDEX_BITS-1:0] cpu_idx, lat_idx;
  logic [TAG_W-1:0]      cpu_tag, lat_tag;
  logic                  cpu_hit, lat_hit;
  logic                  line_we;
  logic [31:0]           line_data;
  logic                  stall_c, rd_hit_out;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  always_comb begin
    cpu_wdata_w = '0;
    mem_rdata_w = '0;
    for (int i = 0; i < 4; i++) begin
      cpu_wdata_w[8*i +: 8] = cpu_wdata[i];
      mem_rdata_w[8*i +: 8] = mem_rdata[i];
    end
  end

  assign cpu_idx = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag = cpu_addr[XLEN-1:INDEX_BITS+2];
  assign lat_idx = addr_q[INDEX_BITS+1:2];
  assign lat_tag = addr_q[XLEN-1:INDEX_BITS+2];
  assign cpu_hit = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_mem[lat_idx] == lat_tag);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    line_we    = 1'b0;
    line_data  = mem_rdata_w;
    stall_c    = 1'b0;
    rd_hit_out = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          stall_c = 1'b1;
          addr_d  = {cpu_addr[XLEN-1:2], 2'b00};
          wdata_d = cpu_wdata_w;
          state_d = WR_THRU;
        end else if (cpu_read) begin
          if (cpu_hit) begin
            rd_hit_out = 1'b1;
            rdata_d    = data_mem[cpu_idx];
            if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            stall_c = 1'b1;
            addr_d  = {cpu_addr[XLEN-1:2], 2'b00};
            if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall_c  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          line_we          = 1'b1;
          valid_d[lat_idx] = 1'b1;
          rdata_d          = mem_rdata_w;
          state_d          = RESP;
        end
      end
      WR_THRU: begin
        stall_c   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          // No-write-allocate: only a line that already holds this word is refreshed.
          line_we   = lat_hit;
          line_data = wdata_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While reset is held the FSM sits in IDLE; a pending request must not raise stall.
  assign cpu_stall = stall_c & rst_b;
  assign rdata_out = rd_hit_out ? data_mem[cpu_idx] : rdata_q;
  assign mem_addr  = addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cpu_rdata[i] = rdata_out[8*i +: 8];
      mem_wdata[i] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= line_data;
    end
  end

endmodule
